pipelined_memory: RTL and testbench
===================================

# pipelined_memory

Parametrised byte-addressable RAM with a valid/ready request port, a fixed-latency response pipeline, and byte/halfword/word/doubleword access sizes. After reset it runs a sequential fill pass that loads a fill pattern into every word, so uninitialised space executes as NOP. It serves as the CPU's instruction/data RAM and MMIO backing store, and replaces the single-cycle combinational-read memory. Address decode reports misaligned and out-of-range accesses as errors instead of returning X.

## Interface
- NUM_OF_BYTES, 1024, capacity in bytes; must be a multiple of DATA_WIDTH/8.
- DATA_WIDTH, 32, word width; 32 or 64.
- READ_LATENCY, 1, cycles from request acceptance to response; range 1..4.
- FILL_PATTERN, 32'hE1A00000, 32-bit fill value (MOV R0, R0), replicated across DATA_WIDTH.
- clk  in  1  single clock; all state changes on posedge.
- mem_reset  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_address  in  32  byte address.
- req_size  in  2  log2 of access bytes: 0 = byte, 1 = half, 2 = word, 3 = doubleword.
- req_write_data  in  DATA_WIDTH  write data, right-aligned (bits [8·n−1:0] used).
- resp_valid  out  1  response present, one-cycle pulse per accepted request.
- resp_read_data  out  DATA_WIDTH  read data, zero-extended, right-aligned; 0 for writes and errors.
- resp_error  out  1  accepted request was misaligned, out of range, or of illegal size.
- init_busy  out  1  fill pass in progress.

## Operation
- Byte order is little-endian: the byte at address A occupies bits [7:0], A+1 occupies [15:8], and so on.
- FSM states:
  - INIT: on mem_reset, clear the word counter and enter INIT. Write the fill word to word index k each cycle, k = 0 .. NUM_OF_BYTES/(DATA_WIDTH/8)−1. After the last word, go to RUN.
  - RUN: req_ready = 1.
- A request is accepted when req_valid && req_ready. At most one request is accepted per cycle. There is no response backpressure.
- Error conditions (any one sets the error):
  - A mod 2^size ≠ 0
  - A + 2^size > NUM_OF_BYTES
  - 2^size > DATA_WIDTH/8
- On an error request: no memory write; the response has resp_error = 1 and data 0.
- Valid write: update only the 2^size addressed bytes. All other bytes are unchanged.
- Valid read: return the 2^size bytes at A, zero-extended.
- Every accepted request, read or write, produces exactly one response. Responses return in acceptance order.
- Bus arithmetic: address compares use 33-bit sums so that A near 2^32 cannot wrap into range.

## Timing
- Reset values:
  - req_ready = 0, resp_valid = 0, resp_read_data = 0, resp_error = 0, init_busy = 1.
  - The response pipeline is cleared.
- Init duration: exactly NUM_OF_BYTES/(DATA_WIDTH/8) cycles after the cycle in which mem_reset deasserts. Default: 256 cycles.
  - init_busy falls and req_ready rises in the same cycle.
- Response timing: a request accepted at edge t produces resp_valid at edge t+READ_LATENCY, held for one cycle.
  - Back-to-back requests give back-to-back responses.
- Read data reflects every write accepted at an earlier edge.
  - A write at edge t followed by a read of the same bytes at edge t+1 returns the new data, for any READ_LATENCY.
- A request presented while req_ready = 0 is ignored. There is no response, and the requester must hold it.
- mem_reset asserted mid-operation:
  - In-flight responses are dropped; resp_valid = 0 from the next cycle.
  - Any write accepted in the reset cycle is discarded.
  - INIT restarts from word 0, so contents are refilled.
- mem_reset held high: the block remains in the reset state and the counter stays at 0.

## Test plan
- Reset then idle:
  - init_busy stays 1 for 256 cycles (defaults), then req_ready = 1.
  - Word reads at 0x000, 0x1FC and 0x3FC return 0xE1A00000 after 1 cycle, with resp_error = 0.
- Sub-word write:
  - Sequence: word write 0x11223344 @0x10, then byte write 0xAA @0x11, then half write 0xBEEF @0x12.
  - A word read @0x10 returns 0xBEEFAA44.
  - A byte read @0x13 returns 0x000000BE.
- Errors, each giving resp_error = 1, resp_read_data = 0, and memory unchanged:
  - half @0x01
  - word @0x3FE
  - word @0xFFFFFFFC
  - req_size 3 with DATA_WIDTH = 32
  - Follow-up: a word read @0x3FC still returns 0xE1A00000.
- Pipeline, READ_LATENCY = 3:
  - Issue 4 back-to-back requests: write 0x5 @0x20, then read @0x20, read @0x24, read @0x20.
  - Responses appear at edges t+3..t+6, in order.
  - Read data: 0x5, 0xE1A00000, 0x5.
- Reset mid-stream:
  - With 2 reads in flight, pulse mem_reset for 1 cycle. No resp_valid follows, and init_busy = 1 for 256 cycles.
  - A read of a previously written address then returns the fill pattern.
- DATA_WIDTH = 64, NUM_OF_BYTES = 64:
  - Init takes 8 cycles.
  - Doubleword write 0x0123456789ABCDEF @0x8, then word read @0xC returns 0x01234567.

Source files
------------

// File: rtl/pipelined_memory.sv
// Byte-addressable RAM with a valid/ready request port, a fixed-latency response pipeline and
// a post-reset fill pass that loads FILL_PATTERN into every word.
module pipelined_memory #(
    parameter int unsigned NUM_OF_BYTES = 1024,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] FILL_PATTERN = 32'hE1A00000
) (
    input  logic                  clk,
    input  logic                  mem_reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_address,
    input  logic [1:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_write_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_read_data,
    output logic                  resp_error,
    output logic                  init_busy
);

    localparam int unsigned BPW       = DATA_WIDTH / 8;
    localparam int unsigned NUM_WORDS = NUM_OF_BYTES / BPW;
    localparam int unsigned OFF_W     = $clog2(BPW);
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [DATA_WIDTH-1:0] FILL_WORD = {(DATA_WIDTH / 32){FILL_PATTERN}};

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic                  state;
    logic [IDX_W-1:0]      init_cnt;
    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    logic                  accept;
    logic [OFF_W-1:0]      offset;
    logic [IDX_W-1:0]      word_idx;
    logic [32:0]           end_addr;
    logic                  size_err, align_err, range_err, req_err;
    logic [BPW-1:0]        lane_en, byte_en;
    logic [DATA_WIDTH-1:0] wdata_sh, rd_sh, rd_data;

    logic                  pipe_valid [READ_LATENCY];
    logic                  pipe_err   [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_data  [READ_LATENCY];

    assign req_ready = (state == ST_RUN);
    assign init_busy = (state == ST_INIT);
    // A request coinciding with reset is dropped, including any write it carries.
    assign accept    = req_valid && req_ready && !mem_reset;

    always_ff @(posedge clk) begin
        if (mem_reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            if (init_cnt == IDX_W'(NUM_WORDS - 1)) begin
                state <= ST_RUN;
            end else begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // 33-bit end address so that addresses near 2^32 cannot wrap back into range.
    assign offset    = req_address[OFF_W-1:0];
    assign word_idx  = req_address[OFF_W +: IDX_W];
    assign end_addr  = {1'b0, req_address} + (33'd1 << req_size);
    assign size_err  = {30'd0, req_size} > OFF_W;
    assign align_err = (req_address & ((32'd1 << req_size) - 32'd1)) != 32'd0;
    assign range_err = end_addr > 33'(NUM_OF_BYTES);
    assign req_err   = size_err || align_err || range_err;

    assign byte_en  = lane_en << offset;
    assign wdata_sh = req_write_data << {offset, 3'b000};
    assign rd_sh    = mem[word_idx] >> {offset, 3'b000};

    always_comb begin
        lane_en = '0;
        rd_data = '0;
        for (int b = 0; b < BPW; b++) begin
            lane_en[b] = 32'(b) < (32'd1 << req_size);
            rd_data[8*b +: 8] = lane_en[b] ? rd_sh[8*b +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!mem_reset && state == ST_INIT) begin
            mem[init_cnt] <= FILL_WORD;
        end else if (accept && req_write && !req_err) begin
            for (int b = 0; b < BPW; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Read data is captured at acceptance, so it already sees every earlier write.
    always_ff @(posedge clk) begin
        if (mem_reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_err[i]   <= 1'b0;
                pipe_data[i]  <= '0;
            end
            resp_valid     <= 1'b0;
            resp_error     <= 1'b0;
            resp_read_data <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && req_err;
            pipe_data[0]  <= (accept && !req_write && !req_err) ? rd_data : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
            resp_valid     <= pipe_valid[READ_LATENCY-1];
            resp_error     <= pipe_err[READ_LATENCY-1];
            resp_read_data <= pipe_data[READ_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_pipelined_memory.sv
// Directed bench for pipelined_memory: three instances (default, READ_LATENCY=3, 64-bit/64-byte)
// share one request bus; expected responses are queued at issue and popped as responses arrive.
module tb_pipelined_memory;

    localparam logic [31:0] FILL   = 32'hE1A00000;
    localparam logic [63:0] FILL64 = {FILL, FILL};

    typedef struct {
        string       tag;
        logic [63:0] data;
        logic        err;
        int unsigned due;
    } entry_t;

    logic        clk = 1'b0;
    logic        mem_reset = 1'b0;
    logic        req_valid = 1'b0;
    int          req_sel = 0;
    logic        req_write = 1'b0;
    logic [31:0] req_address = '0;
    logic [1:0]  req_size = '0;
    logic [63:0] req_wdata = '0;

    logic va, vb, vc;
    logic ready_a, rv_a, err_a, busy_a;
    logic ready_b, rv_b, err_b, busy_b;
    logic ready_c, rv_c, err_c, busy_c;
    logic [31:0] rd_a, rd_b;
    logic [63:0] rd_c;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    entry_t      q_a[$], q_b[$], q_c[$];

    assign va = req_valid && (req_sel == 0);
    assign vb = req_valid && (req_sel == 1);
    assign vc = req_valid && (req_sel == 2);

    pipelined_memory dut_a (
        .clk(clk), .mem_reset(mem_reset), .req_valid(va), .req_ready(ready_a),
        .req_write(req_write), .req_address(req_address), .req_size(req_size),
        .req_write_data(req_wdata[31:0]), .resp_valid(rv_a), .resp_read_data(rd_a),
        .resp_error(err_a), .init_busy(busy_a)
    );

    pipelined_memory #(.READ_LATENCY(3)) dut_b (
        .clk(clk), .mem_reset(mem_reset), .req_valid(vb), .req_ready(ready_b),
        .req_write(req_write), .req_address(req_address), .req_size(req_size),
        .req_write_data(req_wdata[31:0]), .resp_valid(rv_b), .resp_read_data(rd_b),
        .resp_error(err_b), .init_busy(busy_b)
    );

    pipelined_memory #(.DATA_WIDTH(64), .NUM_OF_BYTES(64)) dut_c (
        .clk(clk), .mem_reset(mem_reset), .req_valid(vc), .req_ready(ready_c),
        .req_write(req_write), .req_address(req_address), .req_size(req_size),
        .req_write_data(req_wdata), .resp_valid(rv_c), .resp_read_data(rd_c),
        .resp_error(err_c), .init_busy(busy_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input int sel, input logic [63:0] data, input logic err);
        entry_t e;
        int n;
        case (sel)
            0: n = q_a.size();
            1: n = q_b.size();
            default: n = q_c.size();
        endcase
        n_checks++;
        assert (n > 0)
        else begin
            n_fail++;
            $error("FAIL spurious_resp dut%0d: observed response data %h, expected none", sel, data);
        end
        if (n > 0) begin
            case (sel)
                0: e = q_a.pop_front();
                1: e = q_b.pop_front();
                default: e = q_c.pop_front();
            endcase
            check({e.tag, " data"}, data, e.data);
            check({e.tag, " error"}, {63'd0, err}, {63'd0, e.err});
            check({e.tag, " edge"}, 64'(cyc), 64'(e.due));
        end
    endtask

    always @(negedge clk) begin
        if (rv_a) pop_check(0, {32'd0, rd_a}, err_a);
        if (rv_b) pop_check(1, {32'd0, rd_b}, err_b);
        if (rv_c) pop_check(2, rd_c, err_c);
    end

    // Drives one request for a single cycle; the response is expected READ_LATENCY edges later.
    task automatic issue(input int sel, input string tag, input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic [63:0] wdata,
                         input logic [63:0] exp_data, input logic exp_err);
        entry_t e;
        logic rdy;
        req_sel = sel;
        req_write = wr;
        req_address = addr;
        req_size = size;
        req_wdata = wdata;
        req_valid = 1'b1;
        rdy = (sel == 0) ? ready_a : (sel == 1) ? ready_b : ready_c;
        check({tag, " req_ready"}, {63'd0, rdy}, 64'd1);
        @(posedge clk);
        #1;
        e.tag = tag;
        e.data = exp_data;
        e.err = exp_err;
        e.due = cyc + ((sel == 1) ? 32'd3 : 32'd1);
        case (sel)
            0: q_a.push_back(e);
            1: q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic measure_init(input int hold);
        int na, nb, nc;
        na = -1;
        nb = -1;
        nc = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (n == hold) req_valid = 1'b0;
            if (na < 0 && busy_a === 1'b0) begin
                na = n;
                check("ready_a with init end", {63'd0, ready_a}, 64'd1);
            end
            if (nb < 0 && busy_b === 1'b0) begin
                nb = n;
                check("ready_b with init end", {63'd0, ready_b}, 64'd1);
            end
            if (nc < 0 && busy_c === 1'b0) begin
                nc = n;
                check("ready_c with init end", {63'd0, ready_c}, 64'd1);
            end
            if (na >= 0 && nb >= 0 && nc >= 0) break;
        end
        check("init cycles a", 64'(na), 64'd256);
        check("init cycles b", 64'(nb), 64'd256);
        check("init cycles c", 64'(nc), 64'd8);
    endtask

    initial begin
        mem_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", {63'd0, ready_a}, 64'd0);
        check("reset resp_valid", {63'd0, rv_a}, 64'd0);
        check("reset resp_read_data", {32'd0, rd_a}, 64'd0);
        check("reset resp_error", {63'd0, err_a}, 64'd0);
        check("reset init_busy", {63'd0, busy_a}, 64'd1);
        check("reset c resp_read_data", rd_c, 64'd0);
        mem_reset = 1'b0;
        measure_init(0);

        issue(0, "rd 0x000", 1'b0, 32'h000, 2'd2, 64'd0, {32'd0, FILL}, 1'b0);
        issue(0, "rd 0x1FC", 1'b0, 32'h1FC, 2'd2, 64'd0, {32'd0, FILL}, 1'b0);
        issue(0, "rd 0x3FC", 1'b0, 32'h3FC, 2'd2, 64'd0, {32'd0, FILL}, 1'b0);

        issue(0, "wr word 0x10", 1'b1, 32'h010, 2'd2, 64'h11223344, 64'd0, 1'b0);
        issue(0, "wr byte 0x11", 1'b1, 32'h011, 2'd0, 64'hAA, 64'd0, 1'b0);
        issue(0, "wr half 0x12", 1'b1, 32'h012, 2'd1, 64'hBEEF, 64'd0, 1'b0);
        issue(0, "rd word 0x10", 1'b0, 32'h010, 2'd2, 64'd0, 64'hBEEFAA44, 1'b0);
        issue(0, "rd byte 0x13", 1'b0, 32'h013, 2'd0, 64'd0, 64'h000000BE, 1'b0);

        issue(0, "err half 0x01", 1'b1, 32'h001, 2'd1, 64'hFFFF, 64'd0, 1'b1);
        issue(0, "err word 0x3FE", 1'b1, 32'h3FE, 2'd2, 64'hFFFFFFFF, 64'd0, 1'b1);
        issue(0, "err word top", 1'b1, 32'hFFFFFFFC, 2'd2, 64'hFFFFFFFF, 64'd0, 1'b1);
        issue(0, "err size3", 1'b1, 32'h3F8, 2'd3, 64'hFFFFFFFF, 64'd0, 1'b1);
        issue(0, "err rd word 0x3FE", 1'b0, 32'h3FE, 2'd2, 64'd0, 64'd0, 1'b1);
        issue(0, "post-err 0x3FC", 1'b0, 32'h3FC, 2'd2, 64'd0, {32'd0, FILL}, 1'b0);
        issue(0, "post-err 0x3F8", 1'b0, 32'h3F8, 2'd2, 64'd0, {32'd0, FILL}, 1'b0);
        issue(0, "post-err 0x000", 1'b0, 32'h000, 2'd2, 64'd0, {32'd0, FILL}, 1'b0);
        idle(3);

        issue(1, "b wr 0x20", 1'b1, 32'h020, 2'd2, 64'h5, 64'd0, 1'b0);
        issue(1, "b rd 0x20", 1'b0, 32'h020, 2'd2, 64'd0, 64'h5, 1'b0);
        issue(1, "b rd 0x24", 1'b0, 32'h024, 2'd2, 64'd0, {32'd0, FILL}, 1'b0);
        issue(1, "b rd 0x20 again", 1'b0, 32'h020, 2'd2, 64'd0, 64'h5, 1'b0);
        idle(6);

        issue(2, "c wr dword 0x8", 1'b1, 32'h008, 2'd3, 64'h0123456789ABCDEF, 64'd0, 1'b0);
        issue(2, "c rd word 0xC", 1'b0, 32'h00C, 2'd2, 64'd0, 64'h01234567, 1'b0);
        issue(2, "c rd word 0x8", 1'b0, 32'h008, 2'd2, 64'd0, 64'h89ABCDEF, 1'b0);
        issue(2, "c rd byte 0xF", 1'b0, 32'h00F, 2'd0, 64'd0, 64'h01, 1'b0);
        issue(2, "c rd dword 0x0", 1'b0, 32'h000, 2'd3, 64'd0, FILL64, 1'b0);
        issue(2, "c rd word 0x3C", 1'b0, 32'h03C, 2'd2, 64'd0, {32'd0, FILL}, 1'b0);
        issue(2, "c err word 0x40", 1'b0, 32'h040, 2'd2, 64'd0, 64'd0, 1'b1);
        idle(3);

        // Two reads in flight on the 3-cycle instance, then a one-cycle reset pulse.
        issue(1, "b inflight 0", 1'b0, 32'h020, 2'd2, 64'd0, 64'h5, 1'b0);
        issue(1, "b inflight 1", 1'b0, 32'h024, 2'd2, 64'd0, {32'd0, FILL}, 1'b0);
        mem_reset = 1'b1;
        @(posedge clk);
        #1;
        q_b.delete();
        check("b resp_valid after reset", {63'd0, rv_b}, 64'd0);
        check("b init_busy after reset", {63'd0, busy_b}, 64'd1);
        mem_reset = 1'b0;
        // A write held while not ready must be ignored.
        req_sel = 1;
        req_write = 1'b1;
        req_address = 32'h024;
        req_size = 2'd2;
        req_wdata = 64'h77;
        req_valid = 1'b1;
        measure_init(50);

        issue(1, "b refill 0x20", 1'b0, 32'h020, 2'd2, 64'd0, {32'd0, FILL}, 1'b0);
        issue(1, "b refill 0x24", 1'b0, 32'h024, 2'd2, 64'd0, {32'd0, FILL}, 1'b0);
        issue(0, "a refill 0x10", 1'b0, 32'h010, 2'd2, 64'd0, {32'd0, FILL}, 1'b0);
        issue(2, "c refill 0x8", 1'b0, 32'h008, 2'd3, 64'd0, FILL64, 1'b0);
        idle(8);
        check("responses drained", 64'(q_a.size() + q_b.size() + q_c.size()), 64'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
